// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring divide, sign fix on the last edge.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        a_neg_s, b_neg_s, accept_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] rem_sh_s;
    logic [33:0] diff_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s, rem_s;

    // Operand magnitudes and the per-iteration datapath.
    always_comb begin
        a_neg_s    = op[0] & a[31];
        b_neg_s    = op[0] & b[31];
        a_mag_s    = a_neg_s ? neg32(a) : a;
        b_mag_s    = b_neg_s ? neg32(b) : b;
        // A divide by zero is a no-op, so it must not block mthi/mtlo either.
        accept_s   = start & ~(op[1] & (b == 32'd0));
        mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
        mul_next_s = {mul_sum_s, acc_q[31:1]};
        rem_sh_s   = acc_q[63:31];
        diff_s     = {1'b0, rem_sh_s} - {2'b00, opb_q};
        if (!diff_s[33]) begin
            div_next_s = {diff_s[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
        end
        prod_s = (op_q[0] & (neg_a_q ^ neg_b_q)) ? neg64(acc_q) : acc_q;
        quot_s = (op_q[0] & (neg_a_q ^ neg_b_q)) ? neg32(acc_q[31:0]) : acc_q[31:0];
        rem_s  = (op_q[0] & neg_a_q) ? neg32(acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state logic for the IDLE / CALC / FIX controller and HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    op_d    = op;
                    neg_a_d = a_neg_s;
                    neg_b_d = b_neg_s;
                    opa_d   = a_mag_s;
                    opb_d   = b_mag_s;
                    acc_d   = op[1] ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
                end else begin
                    hi_d = mthi ? wdata : hi_q;
                    lo_d = mtlo ? wdata : lo_q;
                end
            end
            S_CALC: begin
                acc_d = op_q[1] ? div_next_s : mul_next_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (op_q[1]) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end else begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            acc_q   <= 64'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, busy length, and
// the start/mthi/mtlo/reset interaction corner cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    int n;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (E0), then scramble the operand inputs.
    task automatic start_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count busy cycles; optionally poke start (kind 1) or mtlo (kind 2) at cycle poke_at.
    task automatic wait_done(output int cyc, input int kind, input int poke_at);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            start = (kind == 1 && cyc == poke_at);
            mtlo  = (kind == 2 && cyc == poke_at);
            op    = OP_MULTU;
            a     = 32'd3;
            b     = 32'd3;
            wdata = 32'hDEADBEEF;
            tick();
        end
        start = 1'b0;
        mtlo  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, 0, 0);
        chk("multu_busy_cycles", n, 32'd33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        start_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005);
        wait_done(n, 0, 0);
        chk("mult_busy_cycles", n, 32'd33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        start_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_done(n, 0, 0);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done(n, 1, 10);
        chk("divu_restart_cycles", n, 32'd33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        mthi = 1'b1; wdata = 32'h12345678;
        tick();
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'd14);

        start_op(OP_DIVU, 32'd55, 32'd0);
        chk("div0_busy_e0", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("div0_busy_later", {31'd0, busy}, 32'd0);
        chk("div0_hi", hi, 32'h12345678);
        chk("div0_lo", lo, 32'd14);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA5555;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_hi", hi, 32'hAAAA5555);
        chk("mthilo_lo", lo, 32'hAAAA5555);

        start_op(OP_MULTU, 32'd2, 32'd3);
        chk("calc_hold_hi", hi, 32'hAAAA5555);
        chk("calc_hold_lo", lo, 32'hAAAA5555);
        wait_done(n, 2, 5);
        chk("mtlo_busy_hi", hi, 32'd0);
        chk("mtlo_busy_lo", lo, 32'd6);

        start_op(OP_MULTU, 32'd7, 32'd9);
        for (int i = 0; i < 14; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("rst_late_busy", {31'd0, busy}, 32'd0);
        chk("rst_late_lo", lo, 32'd0);

        op = OP_DIV; a = 32'h80000000; b = 32'hFFFFFFFF;
        mtlo = 1'b1; wdata = 32'hCAFEBABE; start = 1'b1;
        tick();
        start = 1'b0; mtlo = 1'b0;
        chk("start_mtlo_lo_kept", lo, 32'd0);
        wait_done(n, 0, 0);
        chk("div_ovf_cycles", n, 32'd33);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);

        start_op(OP_MULTU, 32'h00010000, 32'h00010000);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_hold_lo", lo, 32'h80000000);
        wait_done(n, 0, 0);
        chk("b2b_cycles", n, 32'd33);
        chk("b2b_hi", hi, 32'h00000001);
        chk("b2b_lo", lo, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, listed as the first two ports below.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on the rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin the operation selected by op.
REQ-005 op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  operand A (multiplicand or dividend), taken from the A operand register.
REQ-007 b  input  32  operand B (multiplier or divisor), taken from the B operand register.
REQ-008 mthi  input  1  write wdata to HI.
REQ-009 mtlo  input  1  write wdata to LO.
REQ-010 wdata  input  32  data for mthi and mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 hi  output  32  HI register: product[63:32] or remainder.
REQ-013 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 In IDLE, start SHALL be accepted at the edge where it is sampled high (edge E0).
  - On acceptance the block SHALL latch op, a and b; a and b may change afterwards.
  - busy SHALL go high after E0.
REQ-016 CALC SHALL run exactly 32 iterations on edges E1..E32, one bit per edge.
  - Multiply: shift-add.
  - Divide: restoring.
REQ-017 Signed ops (MULT, DIV) SHALL operate on magnitudes and apply a sign fix in FIX.
REQ-018 FIX (edge E33) SHALL write hi and lo, return to IDLE and deassert busy.
  - busy SHALL be high for exactly 33 cycles.
  - New results SHALL be visible in the cycle after E33.
REQ-019 hi and lo SHALL hold their previous values throughout CALC.
  - They SHALL change only at FIX, on mthi/mtlo, or on reset.
REQ-020 Multiply SHALL produce the full 64-bit product {hi,lo}: unsigned for MULTU, two's-complement for MULT.
REQ-021 DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no exception.
REQ-023 DIVU or DIV with b==0 at start SHALL be treated as a no-op.
  - busy SHALL stay low.
  - hi and lo SHALL be unchanged.
  - The block SHALL stay in IDLE.
REQ-024 start SHALL be ignored while busy=1; the operation in progress SHALL not be disturbed.
REQ-025 mthi/mtlo SHALL be ignored while busy=1.
  - In IDLE they SHALL write wdata at the sampling edge.
  - mthi and mtlo together SHALL write both registers.
REQ-026 If start (valid, non-div-by-zero) and mthi/mtlo are both high in IDLE, start SHALL take precedence and mthi/mtlo SHALL be ignored.
REQ-027 A back-to-back start in the first cycle after FIX SHALL be accepted.
  - That start SHALL see the just-written hi and lo.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL:
  - set state to IDLE;
  - set busy=0, hi=0x00000000 and lo=0x00000000;
  - clear all iteration counters and internal operand/accumulator registers.
REQ-029 Reset during CALC or FIX SHALL abandon the operation; no partial result SHALL reach hi or lo.
REQ-030 start, mthi and mtlo sampled in a reset cycle SHALL be ignored.

Verification
REQ-031 The bench SHALL cover all of the following directed scenarios:
  - MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
  - MULT a=0xFFFFFFFD (-3), b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 -> lo=14, hi=2. Second start pulsed at cycle 10 -> ignored; result unchanged and still completes on edge E33.
  - mthi wdata=0x12345678, then DIVU b=0 -> busy never asserts; hi=0x12345678 and lo unchanged. mtlo asserted during busy -> lo not written.
  - MULTU 7*9 started; rst_n=0 at cycle 15 -> busy=0, hi=0, lo=0 next cycle; no later write of 63.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. start+mtlo asserted together in IDLE -> operation runs and lo is not written from wdata.
